gnn_node_sched: RTL and testbench
=================================

GNN_NODE_SCHED -- requirements
Module: gnn_node_sched

Interface
REQ-001 SHALL have parameter FW, default 5, meaning feature/weight operand width (unsigned).
REQ-002 SHALL have parameter OW, default 21, meaning result width per output.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand set offered.
REQ-006 SHALL have port in_ready  output  1  scheduler can accept an operand set.
REQ-007 SHALL have port x_flat  input  16*FW  node features; slice n*4+i = feature x_i of node n.
REQ-008 SHALL have port w1_flat  input  16*FW  layer-1 weights; slice i*4+k = weight w(i)(4+k).
REQ-009 SHALL have port w2_flat  input  8*FW  layer-2 weights; slice k*2+o = weight w(4+k)(8+o).
REQ-010 SHALL have port out_valid  output  1  results complete and held.
REQ-011 SHALL have port out_ready  input  1  consumer takes results.
REQ-012 SHALL have port out_flat  output  8*OW  results; slice n*2+o = out_o of node n.
REQ-013 SHALL have port node_done  output  4  bit n set once both outputs of node n are written.
REQ-014 SHALL have port busy  output  1  high in L1 or L2 state.

Function
REQ-015 SHALL time-share exactly one FW x FW unsigned multiplier and one accumulator across all 4 nodes and both layers.
REQ-016 SHALL implement FSM states IDLE, L1, L2, DONE; in_ready = (state==IDLE).
REQ-017 SHALL, on in_valid && in_ready, latch x_flat, w1_flat, w2_flat internally, clear node_done, node index n=0, go to L1.
REQ-018 SHALL ignore x_flat/w1_flat/w2_flat changes after acceptance.
REQ-019 SHALL in L1 perform one MAC per cycle, k outer 0..3, i inner 0..3: h_k = sum_i x_i*w(i)(4+k); 16 cycles; h_k stored 12 bits, no truncation.
REQ-020 SHALL in L2 perform one MAC per cycle, o outer 0..1, k inner 0..3: out_o = sum_k h_k*w(4+k)(8+o); 8 cycles; result zero-extended to OW.
REQ-021 SHALL write out_o into out_flat slice n*2+o on the cycle its fourth term accumulates; set node_done[n] with the out_1 write.
REQ-022 SHALL after L2 of node n<3 go to L1 with n+1; after node 3 go to DONE.
REQ-023 SHALL assert out_valid on the 96th rising edge after the acceptance edge (24 MAC cycles per node, no idle cycles).
REQ-024 SHALL hold out_valid and out_flat stable in DONE while out_ready is low.
REQ-025 SHALL on out_valid && out_ready return to IDLE; in_ready high the following cycle; out_flat retains values until next write.
REQ-026 SHALL keep in_valid without effect outside IDLE.
REQ-027 SHALL guarantee no overflow: max operand 31 gives result 476656 < 2^19.

Reset
REQ-028 SHALL on rst (any state, including mid-L1/L2) next edge: state IDLE, in_ready 1, out_valid 0, busy 0, node_done 0, out_flat 0, accumulator and h_k 0.
REQ-029 SHALL give rst priority over every handshake on the same edge.

Configuration
REQ-030 SHALL, with GNN_SCHED_ABORT_EN defined, add port abort input 1; abort high in L1 or L2 -> next edge IDLE, node_done 0, out_valid 0, out_flat unchanged; abort ignored in IDLE/DONE.
REQ-031 SHALL, without GNN_SCHED_ABORT_EN, have no abort port and only rst terminates a computation.

Verification
REQ-032 SHALL cover: rst held 2 cycles -> in_ready 1, out_valid 0, out_flat 0, node_done 0.
REQ-033 SHALL cover: all x and all weights = 1 -> every out_flat slice = 16, out_valid exactly 96 cycles after accept, node_done bits set at cycles 24/48/72/96.
REQ-034 SHALL cover: node0 x=(4,2,4,1), w04..w34=(3,2,13,26), w05..w35=(23,1,28,14), w06..w36=(3,6,17,15), w07..w37=(9,22,15,22), w48..w78=(0,31,3,21), w49..w79=(20,17,17,6) -> node0 out0=10543, out1=8411.
REQ-035 SHALL cover: all operands 31 -> every slice 476656, upper 2 bits 0.
REQ-036 SHALL cover: out_ready low 10 cycles in DONE with in_valid high -> out_flat stable, in_ready 0, no second accept; out_ready high -> IDLE next cycle.
REQ-037 SHALL cover: rst asserted 40 cycles after accept -> next edge IDLE, node_done 0, out_flat 0; new accept then completes normally.

Source files
------------

// File: rtl/gnn_node_sched.sv
// rtl/gnn_node_sched.sv - single-MAC scheduler for a 4-node, two-layer GNN (4 -> 4 -> 2 per node)
// Parameters : FW operand width, OW result width per output
// Ports      : clk, rst (sync, active-high)
//              in_valid/in_ready + x_flat/w1_flat/w2_flat : operand set handshake
//              out_valid/out_ready + out_flat              : result handshake
//              node_done : per-node completion, busy : computing (L1/L2)
// Option     : GNN_SCHED_ABORT_EN adds input abort (cancel a running computation)
module gnn_node_sched #(
    parameter int FW = 5,
    parameter int OW = 21
) (
    input  logic             clk,
    input  logic             rst,
`ifdef GNN_SCHED_ABORT_EN
    input  logic             abort,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [16*FW-1:0] x_flat,
    input  logic [16*FW-1:0] w1_flat,
    input  logic [8*FW-1:0]  w2_flat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8*OW-1:0]  out_flat,
    output logic [3:0]       node_done,
    output logic             busy
);
    // h_k is a sum of four FW x FW products; the final sum adds four h_k x FW products
    localparam int HW = 2*FW + 2;
    localparam int PW = HW + FW;
    localparam int AW = PW + 2;

    typedef enum logic [1:0] {IDLE, L1, L2, DONE} state_t;

    state_t        state;
    logic [FW-1:0] x_r  [16];
    logic [FW-1:0] w1_r [16];
    logic [FW-1:0] w2_r [8];
    logic [HW-1:0] h    [4];
    logic [AW-1:0] acc;
    logic [OW-1:0] out_r [8];
    logic [1:0]    n;
    // Per-node step: 0..15 layer 1 (k = cnt[3:2], i = cnt[1:0]),
    // 16..23 layer 2 (o = cnt[2], k = cnt[1:0])
    logic [4:0]    cnt;

    // The one shared multiplier; its A operand is wide enough for h_k in layer 2
    logic [HW-1:0] mul_a;
    logic [FW-1:0] mul_b;
    logic [PW-1:0] prod;
    logic [AW-1:0] sum;
    logic          first;

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        first = 1'b0;
        if (state == L1) begin
            mul_a = HW'(x_r[{n, cnt[1:0]}]);
            mul_b = w1_r[{cnt[1:0], cnt[3:2]}];
            first = (cnt[1:0] == 2'd0);
        end else if (state == L2) begin
            mul_a = h[cnt[1:0]];
            mul_b = w2_r[{cnt[1:0], cnt[2]}];
            first = (cnt[1:0] == 2'd0);
        end
    end

    assign prod = PW'(mul_a) * PW'(mul_b);
    // The first term of each dot product restarts the accumulator
    assign sum  = (first ? '0 : acc) + AW'(prod);

    for (genvar s = 0; s < 8; s++) begin : g_out
        assign out_flat[s*OW +: OW] = out_r[s];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            node_done <= '0;
            acc       <= '0;
            n         <= '0;
            cnt       <= '0;
            for (int j = 0; j < 4; j++) h[j] <= '0;
            for (int j = 0; j < 8; j++) out_r[j] <= '0;
`ifdef GNN_SCHED_ABORT_EN
        end else if (abort && (state == L1 || state == L2)) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            node_done <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int j = 0; j < 16; j++) begin
                            x_r[j]  <= x_flat[j*FW +: FW];
                            w1_r[j] <= w1_flat[j*FW +: FW];
                        end
                        for (int j = 0; j < 8; j++) w2_r[j] <= w2_flat[j*FW +: FW];
                        node_done <= '0;
                        n         <= '0;
                        cnt       <= '0;
                        state     <= L1;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                L1: begin
                    acc <= sum;
                    if (cnt[1:0] == 2'd3) h[cnt[3:2]] <= sum[HW-1:0];
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd15) state <= L2;
                end
                L2: begin
                    acc <= sum;
                    if (cnt[1:0] == 2'd3) begin
                        out_r[{n, cnt[2]}] <= OW'(sum);
                        if (cnt[2]) node_done[n] <= 1'b1;
                    end
                    if (cnt == 5'd23) begin
                        cnt <= '0;
                        if (n == 2'd3) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            n     <= n + 2'd1;
                            state <= L1;
                        end
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gnn_node_sched.sv
// tb/tb_gnn_node_sched.sv - randomized self-checking bench for gnn_node_sched with arithmetic reference model
module tb_gnn_node_sched;
    localparam int FW = 5;
    localparam int OW = 21;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [16*FW-1:0] x_flat = '0;
    logic [16*FW-1:0] w1_flat = '0;
    logic [8*FW-1:0]  w2_flat = '0;
    logic             in_ready, out_valid, busy;
    logic [8*OW-1:0]  out_flat;
    logic [3:0]       node_done;

    int errors = 0;
    int checks = 0;

    gnn_node_sched #(.FW(FW), .OW(OW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_flat(x_flat), .w1_flat(w1_flat), .w2_flat(w2_flat),
        .out_valid(out_valid), .out_ready(out_ready), .out_flat(out_flat),
        .node_done(node_done), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: results computed as plain dot products at acceptance,
    // revealed on the schedule each node's outputs become available.
    int         m_phase = 0;   // 0 idle, 1 computing, 2 results held
    int         m_t = 0;       // rising edges since acceptance
    longint     m_res [8];
    longint     m_out [8];
    longint     m_h [4];
    logic [3:0] m_done = '0;
    bit         started = 1'b0;

    always @(posedge clk) begin
        started = 1'b1;
        if (rst) begin
            m_phase = 0;
            m_done  = '0;
            for (int s = 0; s < 8; s++) m_out[s] = 0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                for (int nd = 0; nd < 4; nd++) begin
                    for (int k = 0; k < 4; k++) begin
                        m_h[k] = 0;
                        for (int i = 0; i < 4; i++)
                            m_h[k] += longint'(x_flat[(nd*4+i)*FW +: FW]) * longint'(w1_flat[(i*4+k)*FW +: FW]);
                    end
                    for (int o = 0; o < 2; o++) begin
                        m_res[nd*2+o] = 0;
                        for (int k = 0; k < 4; k++)
                            m_res[nd*2+o] += m_h[k] * longint'(w2_flat[(k*2+o)*FW +: FW]);
                    end
                end
                m_phase = 1;
                m_t     = 0;
                m_done  = '0;
            end
        end else if (m_phase == 1) begin
            m_t++;
            for (int nd = 0; nd < 4; nd++) begin
                if (m_t == 24*nd + 20) m_out[nd*2] = m_res[nd*2];
                if (m_t == 24*nd + 24) begin
                    m_out[nd*2+1] = m_res[nd*2+1];
                    m_done[nd]    = 1'b1;
                end
            end
            if (m_t == 96) m_phase = 2;
        end else begin
            if (out_ready) m_phase = 0;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("in_ready", longint'(in_ready), longint'(m_phase == 0));
            chk("out_valid", longint'(out_valid), longint'(m_phase == 2));
            chk("busy", longint'(busy), longint'(m_phase == 1));
            chk("node_done", longint'(node_done), longint'(m_done));
            for (int s = 0; s < 8; s++)
                chk($sformatf("out_flat[%0d]", s), longint'(out_flat[s*OW +: OW]), m_out[s]);
        end
    end

    function automatic logic [16*FW-1:0] rnd16();
        logic [16*FW-1:0] r;
        for (int j = 0; j < 16; j++) r[j*FW +: FW] = FW'($urandom_range(0, (1 << FW) - 1));
        return r;
    endfunction

    function automatic logic [8*FW-1:0] rnd8();
        logic [8*FW-1:0] r;
        for (int j = 0; j < 8; j++) r[j*FW +: FW] = FW'($urandom_range(0, (1 << FW) - 1));
        return r;
    endfunction

    function automatic logic [16*FW-1:0] const16(input int v);
        logic [16*FW-1:0] r;
        for (int j = 0; j < 16; j++) r[j*FW +: FW] = FW'(v);
        return r;
    endfunction

    function automatic logic [8*FW-1:0] const8(input int v);
        logic [8*FW-1:0] r;
        for (int j = 0; j < 8; j++) r[j*FW +: FW] = FW'(v);
        return r;
    endfunction

    // Accept one operand set, scramble inputs while computing, wait for results,
    // hold them for 'hold' cycles with in_valid high, then release.
    task automatic do_run(input logic [16*FW-1:0] x, input logic [16*FW-1:0] w1,
                          input logic [8*FW-1:0] w2, input int hold, input bit chk_times);
        int cyc;
        logic [8*OW-1:0] snap;
        x_flat   = x;
        w1_flat  = w1;
        w2_flat  = w2;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        x_flat   = rnd16();
        w1_flat  = rnd16();
        w2_flat  = rnd8();
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            cyc++;
            if (chk_times && (cyc == 24 || cyc == 48 || cyc == 72))
                chk($sformatf("node_done_at_%0d", cyc), longint'(node_done), longint'((1 << (cyc / 24)) - 1));
        end
        chk("latency", longint'(cyc), 96);
        chk("node_done_final", longint'(node_done), 15);
        in_valid = 1'b1;
        snap = out_flat;
        for (int c = 0; c < hold; c++) begin
            @(posedge clk); #1;
            chk("hold_stable", longint'(out_flat !== snap), 0);
            chk("hold_in_ready", longint'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("release_in_ready", longint'(in_ready), 1);
        chk("release_out_valid", longint'(out_valid), 0);
    endtask

    int w1a [4][4] = '{'{3, 23, 3, 9}, '{2, 1, 6, 22}, '{13, 28, 17, 15}, '{26, 14, 15, 22}};
    int w2a [4][2] = '{'{0, 20}, '{31, 17}, '{3, 17}, '{21, 6}};
    int x0a [4]    = '{4, 2, 4, 1};

    initial begin
        logic [16*FW-1:0] xv, w1v;
        logic [8*FW-1:0]  w2v;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", longint'(in_ready), 1);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_flat", longint'(|out_flat), 0);
        chk("rst_node_done", longint'(node_done), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All ones: every output is 4*4 = 16
        do_run(const16(1), const16(1), const8(1), 10, 1'b1);
        for (int s = 0; s < 8; s++) chk($sformatf("ones[%0d]", s), longint'(out_flat[s*OW +: OW]), 16);

        // Hand-computed node 0 vector
        xv  = rnd16();
        w1v = '0;
        w2v = '0;
        for (int i = 0; i < 4; i++) xv[i*FW +: FW] = FW'(x0a[i]);
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) w1v[(i*4+k)*FW +: FW] = FW'(w1a[i][k]);
        for (int k = 0; k < 4; k++)
            for (int o = 0; o < 2; o++) w2v[(k*2+o)*FW +: FW] = FW'(w2a[k][o]);
        do_run(xv, w1v, w2v, 2, 1'b0);
        chk("node0_out0", longint'(out_flat[0 +: OW]), 10543);
        chk("node0_out1", longint'(out_flat[OW +: OW]), 8411);

        // Maximum operands
        do_run(const16(31), const16(31), const8(31), 1, 1'b0);
        for (int s = 0; s < 8; s++) begin
            chk($sformatf("max[%0d]", s), longint'(out_flat[s*OW +: OW]), 476656);
            chk($sformatf("max_top[%0d]", s), longint'(out_flat[s*OW + OW - 2 +: 2]), 0);
        end

        // Random operand sets
        for (int r = 0; r < 6; r++) do_run(rnd16(), rnd16(), rnd8(), $urandom_range(0, 5), 1'b0);

        // Reset in the middle of a computation
        x_flat   = rnd16();
        w1_flat  = rnd16();
        w2_flat  = rnd8();
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_in_ready", longint'(in_ready), 1);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_node_done", longint'(node_done), 0);
        chk("midrst_out_flat", longint'(|out_flat), 0);
        do_run(rnd16(), rnd16(), rnd8(), 3, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end
endmodule
